// File: rtl/shift_reg_seq_ctrl_if.sv
// Word-in / serial-out port bundle between a word source and the shift-register sequencer.
interface shift_reg_seq_ctrl_if #(parameter int WIDTH = 8);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             abort;
  logic             shift_en;
  logic             shift_in;
  logic [WIDTH-1:0] shift_q;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output s_valid, s_data, abort, shift_q,
                  input  s_ready, shift_en, shift_in, busy, done, err);
  modport slave  (input  s_valid, s_data, abort, shift_q,
                  output s_ready, shift_en, shift_in, busy, done, err);
endinterface

// File: rtl/shift_reg_seq_ctrl.sv
// Serialises accepted words MSB-first into an external serial-in shift register.
// SRC_VERIFY_EN adds a CHECK cycle that compares the register read-back against the word.
module shift_reg_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input logic                 clk,
  input logic                 reset,
  shift_reg_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             s_ready_q, s_ready_d;
  logic             shift_en_q, shift_en_d;
  logic             shift_in_q, shift_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IW-1:0]    idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      hold_q     <= '0;
      s_ready_q  <= 1'b0;
      shift_en_q <= 1'b0;
      shift_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      hold_q     <= hold_d;
      s_ready_q  <= s_ready_d;
      shift_en_q <= shift_en_d;
      shift_in_q <= shift_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // cnt_q counts bits already presented; it selects the next bit to drive
  assign idx = IW'(WIDTH - 1 - int'(cnt_q));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    hold_d     = hold_q;
    s_ready_d  = 1'b0;
    shift_en_d = 1'b0;
    shift_in_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready_d = 1'b1;
        if (bus.s_valid && s_ready_q) begin
          hold_d     = bus.s_data;
          state_d    = SHIFT;
          cnt_d      = CW'(1);
          shift_en_d = 1'b1;
          shift_in_d = bus.s_data[WIDTH-1];
          s_ready_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d   = IDLE;
          cnt_d     = '0;
          s_ready_d = 1'b1;
        end else if (cnt_q == CW'(WIDTH)) begin
          cnt_d = '0;
`ifdef SRC_VERIFY_EN
          state_d = CHECK;
`else
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gcnt_d  = GW'(GAP_CYCLES);
          end else begin
            state_d   = IDLE;
            s_ready_d = 1'b1;
          end
`endif
        end else begin
          shift_en_d = 1'b1;
          shift_in_d = hold_q[idx];
          cnt_d      = cnt_q + CW'(1);
        end
      end
`ifdef SRC_VERIFY_EN
      CHECK: begin
        if (bus.abort) begin
          state_d   = IDLE;
          s_ready_d = 1'b1;
        end else begin
          done_d = 1'b1;
          err_d  = (bus.shift_q != hold_q);
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gcnt_d  = GW'(GAP_CYCLES);
          end else begin
            state_d   = IDLE;
            s_ready_d = 1'b1;
          end
        end
      end
`endif
      GAP: begin
        // done cycle plus GAP_CYCLES quiet cycles before accepting again
        if (gcnt_q == '0) begin
          state_d   = IDLE;
          s_ready_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

`ifndef SRC_VERIFY_EN
  logic unused_shift_q;
  assign unused_shift_q = ^bus.shift_q;
`endif

  assign bus.s_ready  = s_ready_q;
  assign bus.shift_en = shift_en_q;
  assign bus.shift_in = shift_in_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Bench for shift_reg_seq_ctrl: behavioural shift register plus a bit/word scoreboard.
module tb_shift_reg_seq_ctrl;
  localparam int W = 8;
`ifdef SRC_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_reg_seq_ctrl_if #(.WIDTH(W)) bus();
  shift_reg_seq_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dut (.clk(clk), .reset(reset), .bus(bus));

  // external serial-in register; corrupt flips bit 0 of the read-back
  logic [W-1:0] q = '0;
  logic corrupt = 1'b0;
  always @(posedge clk) if (bus.shift_en) q <= {q[W-2:0], bus.shift_in};
  assign bus.shift_q = q ^ {{(W-1){1'b0}}, corrupt};

  logic         exp_bit_q[$];
  logic [W-1:0] exp_word_q[$];
  logic         exp_err_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [W-1:0] w, input logic e);
    for (int i = W-1; i >= 0; i--) exp_bit_q.push_back(w[i]);
    exp_word_q.push_back(w);
    exp_err_q.push_back(e);
  endtask

  task automatic test_reset;
    bus.s_valid = 0; bus.s_data = '0; bus.abort = 0; reset = 1;
    repeat (3) tick();
    n_chk++;
    if ({bus.s_ready, bus.shift_en, bus.shift_in, bus.busy, bus.done, bus.err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {bus.s_ready, bus.shift_en, bus.shift_in, bus.busy, bus.done, bus.err});
    end
    reset = 0;
    tick();
    n_chk++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.s_ready); end
    n_chk++;
    if (bus.shift_en !== 1'b0) begin n_fail++; $display("FAIL reset_release_en: got %b want 0", bus.shift_en); end
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single_word;
    int en_cycles, done_at;
    logic b;
    en_cycles = 0; done_at = 0;
    bus.s_valid = 1; bus.s_data = 8'hA5; push_word(8'hA5, 1'b0);
    tick();
    bus.s_valid = 0; bus.s_data = '0;
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      if (bus.shift_en) begin
        en_cycles++;
        b = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
        n_chk++;
        if (bus.shift_in !== b) begin n_fail++; $display("FAIL single_bit%0d: got %b want %b", c, bus.shift_in, b); end
      end
      if (bus.done) begin
        done_at = c;
        n_chk++;
        if (q !== exp_word_q[0]) begin n_fail++; $display("FAIL single_q: got %h want %h", q, exp_word_q[0]); end
        n_chk++;
        if (bus.err !== exp_err_q[0]) begin n_fail++; $display("FAIL single_err: got %b want %b", bus.err, exp_err_q[0]); end
        void'(exp_word_q.pop_front()); void'(exp_err_q.pop_front());
      end
      tick();
    end
    n_chk++;
    if (en_cycles != W) begin n_fail++; $display("FAIL single_en_cycles: got %0d want %0d", en_cycles, W); end
    n_chk++;
    if (done_at != W+1+VER) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", done_at, W+1+VER); end
  endtask

  task automatic test_back_to_back;
    int done_cnt, gap, phase;
    logic acc, b;
    done_cnt = 0; gap = 0; phase = 0;
    bus.s_valid = 1; bus.s_data = 8'h3C; push_word(8'h3C, 1'b0);
    tick();
    bus.s_data = 8'hC3;
    for (int c = 1; c <= 60 && done_cnt < 2; c++) begin
      if (bus.shift_en) begin
        b = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
        n_chk++;
        if (bus.shift_in !== b) begin n_fail++; $display("FAIL b2b_bit c%0d: got %b want %b", c, bus.shift_in, b); end
        if (phase == 1) phase = 2;
      end else if (phase < 2) begin
        phase = 1; gap++;
      end
      if (bus.done) begin
        done_cnt++;
        n_chk++;
        if (exp_word_q.size() == 0 || q !== exp_word_q[0]) begin n_fail++; $display("FAIL b2b_q%0d: got %h", done_cnt, q); end
        else void'(exp_word_q.pop_front());
        if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
        if (done_cnt == 1) begin
          n_chk++;
          if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b want 1", bus.s_ready); end
        end
      end
      acc = bus.s_ready && bus.s_valid;
      tick();
      if (acc) begin push_word(8'hC3, 1'b0); bus.s_valid = 0; end
    end
    bus.s_valid = 0;
    n_chk++;
    if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_chk++;
    if (gap != 1+VER) begin n_fail++; $display("FAIL b2b_gap: got %0d want %0d", gap, 1+VER); end
    n_chk++;
    if (q !== 8'hC3) begin n_fail++; $display("FAIL b2b_final_q: got %h want c3", q); end
  endtask

  task automatic test_abort;
    logic saw_done;
    saw_done = 0;
    bus.s_valid = 1; bus.s_data = 8'hFF;
    tick();
    bus.s_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      n_chk++;
      if (bus.shift_en !== 1'b1) begin n_fail++; $display("FAIL abort_en_c%0d: got %b want 1", c, bus.shift_en); end
      if (c == 4) bus.abort = 1;
      tick();
    end
    bus.abort = 0;
    n_chk++;
    if (bus.shift_en !== 1'b0) begin n_fail++; $display("FAIL abort_en_after: got %b want 0", bus.shift_en); end
    tick();
    n_chk++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", bus.s_ready); end
    repeat (12) begin if (bus.done) saw_done = 1; tick(); end
    n_chk++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    n_chk++;
    if (q !== 8'h3F) begin n_fail++; $display("FAIL abort_partial_q: got %h want 3f", q); end
  endtask

  task automatic test_reset_mid_word;
    logic saw_done;
    saw_done = 0;
    bus.s_valid = 1; bus.s_data = 8'h81;
    tick();
    bus.s_valid = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin reset = 1; bus.abort = 1; end
      tick();
    end
    reset = 0; bus.abort = 0;
    n_chk++;
    if ({bus.shift_en, bus.busy, bus.done} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_outputs: got en,busy,done=%b want 000", {bus.shift_en, bus.busy, bus.done});
    end
    tick();
    n_chk++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", bus.s_ready); end
    repeat (12) begin if (bus.done) saw_done = 1; tick(); end
    n_chk++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: got %b want 0", saw_done); end
    n_chk++;
    if (q !== 8'hF0) begin n_fail++; $display("FAIL rst_mid_partial_q: got %h want f0", q); end
  endtask

`ifdef SRC_VERIFY_EN
  task automatic test_verify;
    logic [W-1:0] w;
    logic e;
    int done_at;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 8'h55 : 8'hAA;
      e = (k == 0);
      corrupt = e;
      done_at = 0;
      bus.s_valid = 1; bus.s_data = w;
      tick();
      bus.s_valid = 0;
      for (int c = 1; c <= 20 && done_at == 0; c++) begin
        if (bus.done) begin
          done_at = c;
          n_chk++;
          if (bus.err !== e) begin n_fail++; $display("FAIL verify_err%0d: got %b want %b", k, bus.err, e); end
        end
        tick();
      end
      n_chk++;
      if (done_at != W+2) begin n_fail++; $display("FAIL verify_latency%0d: got %0d want %0d", k, done_at, W+2); end
    end
    corrupt = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_reset_mid_word();
`ifdef SRC_VERIFY_EN
    test_verify();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
